// File: rtl/mc_pkg.sv
// mc_pkg: shared definitions for the multi-cycle MIPS controller.
//   state_t  : 4-bit FSM state encoding (also exported as dbg_state)
//   OP_*/FN_*: opcode and R-type funct constants
//   ALU_*    : ALUControl encodings
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_RTYPE_EX = 4'd6,
    S_RTYPE_WB = 4'd7,
    S_ORI_EX   = 4'd8,
    S_IMM_WB   = 4'd9,
    S_LUI_WB   = 4'd10,
    S_BRANCH   = 4'd11,
    S_JUMP     = 4'd12,
    S_JAL      = 4'd13,
    S_JR       = 4'd14,
    S_ILLEGAL  = 4'd15
  } state_t;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_ORI = 6'b001101;
  localparam logic [5:0] OP_LUI = 6'b001111;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_JAL = 6'b000011;

  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_JR   = 6'b001000;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b010;

endpackage

// File: rtl/mc_decode.sv
// mc_decode: combinational instruction classifier used on the DECODE cycle.
//   op, funct : instruction fields from IR
//   nxt       : state to enter after DECODE (S_ILLEGAL for unsupported encodings)
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output state_t     nxt
);

  always_comb begin
    nxt = S_ILLEGAL;
    case (op)
      OP_LW, OP_SW: nxt = S_MEMADR;
      OP_R: begin
        case (funct)
          FN_ADDU, FN_SUBU: nxt = S_RTYPE_EX;
          FN_JR:            nxt = S_JR;
          default:          nxt = S_ILLEGAL;
        endcase
      end
      OP_ORI:  nxt = S_ORI_EX;
      OP_LUI:  nxt = S_LUI_WB;
      OP_BEQ:  nxt = S_BRANCH;
      OP_J:    nxt = S_JUMP;
      OP_JAL:  nxt = S_JAL;
      default: nxt = S_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle control FSM for a shared-memory MIPS datapath.
//   clk, reset (sync, active low), op/funct (IR fields), zero (ALU flag),
//   mem_ready (memory access completes this cycle).
//   Outputs: PC/IR/GRF/memory enables, datapath mux selects, ALUControl,
//   instr_done (last cycle of each instruction), illegal (sticky),
//   dbg_state (current state).
module mc_ctrl
  import mc_pkg::*;
#(
  parameter int MEM_HANDSHAKE = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic [1:0] PCSource,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       ExtZero,
  output logic [2:0] ALUControl,
  output logic       instr_done,
  output logic       illegal,
  output logic [3:0] dbg_state
);

  state_t state, state_nxt, dec_nxt;
  logic   rdy, illegal_q;
  logic   pc_we, pc_we_cond, ir_we, reg_we, mem_rd, mem_wr, done;

  // zero is consumed by the datapath together with PCWriteCond.
  logic unused_zero;
  assign unused_zero = zero;

  assign rdy = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;

  mc_decode u_decode (.op(op), .funct(funct), .nxt(dec_nxt));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt == S_ILLEGAL) illegal_q <= 1'b1;
    end
  end

  always_comb begin
    state_nxt  = state;
    pc_we      = 1'b0;
    pc_we_cond = 1'b0;
    ir_we      = 1'b0;
    reg_we     = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    done       = 1'b0;
    PCSource   = 2'b00;
    IorD       = 1'b0;
    RegDst     = 2'b00;
    MemtoReg   = 2'b00;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ExtZero    = 1'b0;
    ALUControl = ALU_ADD;
    case (state)
      S_FETCH: begin
        mem_rd  = 1'b1;
        ALUSrcB = 2'b01;
        ir_we   = rdy;
        pc_we   = rdy;
        if (rdy) state_nxt = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcB   = 2'b11;
        state_nxt = dec_nxt;
      end
      S_MEMADR: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        state_nxt = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        IorD   = 1'b1;
        mem_rd = 1'b1;
        if (rdy) state_nxt = S_MEMWB;
      end
      S_MEMWB: begin
        reg_we    = 1'b1;
        MemtoReg  = 2'b01;
        done      = 1'b1;
        state_nxt = S_FETCH;
      end
      S_MEMWR: begin
        IorD   = 1'b1;
        mem_wr = 1'b1;
        done   = rdy;
        if (rdy) state_nxt = S_FETCH;
      end
      S_RTYPE_EX: begin
        ALUSrcA    = 1'b1;
        ALUControl = (funct == FN_SUBU) ? ALU_SUB : ALU_ADD;
        state_nxt  = S_RTYPE_WB;
      end
      S_RTYPE_WB: begin
        reg_we    = 1'b1;
        RegDst    = 2'b01;
        done      = 1'b1;
        state_nxt = S_FETCH;
      end
      S_ORI_EX: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        ExtZero    = 1'b1;
        ALUControl = ALU_OR;
        state_nxt  = S_IMM_WB;
      end
      S_IMM_WB, S_LUI_WB: begin
        reg_we    = 1'b1;
        MemtoReg  = (state == S_LUI_WB) ? 2'b11 : 2'b00;
        done      = 1'b1;
        state_nxt = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUControl = ALU_SUB;
        pc_we_cond = 1'b1;
        PCSource   = 2'b01;
        done       = 1'b1;
        state_nxt  = S_FETCH;
      end
      S_JUMP, S_JAL: begin
        pc_we    = 1'b1;
        PCSource = 2'b10;
        done     = 1'b1;
        if (state == S_JAL) begin
          // PC already holds PC+4 from FETCH, so the link value is PC itself.
          reg_we   = 1'b1;
          RegDst   = 2'b10;
          MemtoReg = 2'b10;
        end
        state_nxt = S_FETCH;
      end
      S_JR: begin
        pc_we     = 1'b1;
        PCSource  = 2'b11;
        done      = 1'b1;
        state_nxt = S_FETCH;
      end
      default: state_nxt = S_ILLEGAL;  // S_ILLEGAL: locked until reset
    endcase
  end

  // Reset suppresses every side effect in the same cycle, so an aborted
  // instruction never commits a partial write or reports completion.
  assign PCWrite     = pc_we & reset;
  assign PCWriteCond = pc_we_cond & reset;
  assign IRWrite     = ir_we & reset;
  assign RegWrite    = reg_we & reset;
  assign MemRead     = mem_rd & reset;
  assign MemWrite    = mem_wr & reset;
  assign instr_done  = done & reset;
  assign illegal     = illegal_q;
  assign dbg_state   = state;

endmodule

// File: tb/tb_mc_ctrl.sv
module tb_mc_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] op = '0, funct = '0;
  logic       zero = 1'b0, mem_ready = 1'b1;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite;
  logic       ALUSrcA, ExtZero, instr_done, illegal;
  logic [1:0] PCSource, RegDst, MemtoReg, ALUSrcB;
  logic [2:0] ALUControl;
  logic [3:0] dbg_state;

  int n_vec = 0;
  int n_err = 0;

  mc_ctrl #(.MEM_HANDSHAKE(1)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
    .PCSource(PCSource), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ExtZero(ExtZero), .ALUControl(ALUControl), .instr_done(instr_done),
    .illegal(illegal), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pcw, pcwc;
    logic [1:0] pcsrc;
    logic       iord, mr, mw, irw, rw;
    logic [1:0] rdst, m2r;
    logic       srca;
    logic [1:0] srcb;
    logic       ext;
    logic [2:0] alu;
    logic       done, ill;
  } ctrl_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] funct;
    int         lat;
  } vec_t;

  int seq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic ctrl_t act_ctrl();
    return {PCWrite, PCWriteCond, PCSource, IorD, MemRead, MemWrite, IRWrite,
            RegWrite, RegDst, MemtoReg, ALUSrcA, ALUSrcB, ExtZero, ALUControl,
            instr_done, illegal};
  endfunction

  // Control bundle the spec's per-state table calls for.
  function automatic ctrl_t exp_ctrl(int st, logic [5:0] f, logic rdy, logic rst_n);
    ctrl_t c = '0;
    case (st)
      0:  begin c.mr = 1; c.srcb = 2'b01; c.irw = rdy; c.pcw = rdy; end
      1:  c.srcb = 2'b11;
      2:  begin c.srca = 1; c.srcb = 2'b10; end
      3:  begin c.iord = 1; c.mr = 1; end
      4:  begin c.rw = 1; c.m2r = 2'b01; c.done = 1; end
      5:  begin c.iord = 1; c.mw = 1; c.done = rdy; end
      6:  begin c.srca = 1; c.alu = (f == 6'b100011) ? 3'b001 : 3'b000; end
      7:  begin c.rw = 1; c.rdst = 2'b01; c.done = 1; end
      8:  begin c.srca = 1; c.srcb = 2'b10; c.ext = 1; c.alu = 3'b010; end
      9:  begin c.rw = 1; c.done = 1; end
      10: begin c.rw = 1; c.m2r = 2'b11; c.done = 1; end
      11: begin c.srca = 1; c.alu = 3'b001; c.pcwc = 1; c.pcsrc = 2'b01; c.done = 1; end
      12: begin c.pcw = 1; c.pcsrc = 2'b10; c.done = 1; end
      13: begin c.pcw = 1; c.pcsrc = 2'b10; c.rw = 1; c.rdst = 2'b10; c.m2r = 2'b10; c.done = 1; end
      14: begin c.pcw = 1; c.pcsrc = 2'b11; c.done = 1; end
      default: c.ill = 1;
    endcase
    if (!rst_n) begin
      c.pcw = 0; c.pcwc = 0; c.irw = 0; c.rw = 0; c.mr = 0; c.mw = 0; c.done = 0;
    end
    return c;
  endfunction

  // Instruction -> ordered list of states it walks through.
  function automatic void build_seq(logic [5:0] o, logic [5:0] f);
    seq = {0, 1};
    case (o)
      6'b100011: begin seq.push_back(2); seq.push_back(3); seq.push_back(4); end
      6'b101011: begin seq.push_back(2); seq.push_back(5); end
      6'b001101: begin seq.push_back(8); seq.push_back(9); end
      6'b001111: seq.push_back(10);
      6'b000100: seq.push_back(11);
      6'b000010: seq.push_back(12);
      6'b000011: seq.push_back(13);
      6'b000000: begin
        if (f == 6'b100001 || f == 6'b100011) begin seq.push_back(6); seq.push_back(7); end
        else if (f == 6'b001000) seq.push_back(14);
        else seq.push_back(15);
      end
      default: seq.push_back(15);
    endcase
  endfunction

  // Walks one instruction with optionally random mem_ready, checking every cycle.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input bit rnd);
    int idx = 0;
    int guard = 0;
    bit stay;
    build_seq(o, f);
    while (idx < seq.size() && guard < 60) begin
      op = o; funct = f;
      mem_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      zero = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("state", 32'(dbg_state), 32'(seq[idx]));
      chk("ctrl", 32'(act_ctrl()), 32'(exp_ctrl(seq[idx], f, mem_ready, 1'b1)));
      stay = (seq[idx] == 0 || seq[idx] == 3 || seq[idx] == 5) && !mem_ready;
      @(posedge clk); #1;
      if (!stay) idx++;
      guard++;
    end
    if (guard >= 60) chk("instr_timeout", 32'(guard), 32'(0));
  endtask

  // Cycles from FETCH up to and including the instr_done cycle, mem_ready=1.
  task automatic latency(input logic [5:0] o, input logic [5:0] f, input logic z, output int cyc);
    cyc = 0;
    op = o; funct = f; zero = z; mem_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      cyc++;
      if (o == 6'b000100 && dbg_state == 4'd11)
        chk("beq_pcw", 32'({PCWrite, PCWriteCond, PCSource}), 32'(4'b0101));
      if (instr_done) break;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  vec_t vt[10];

  initial begin
    int cyc;
    vt[0] = '{6'b100011, 6'b000000, 5};
    vt[1] = '{6'b101011, 6'b000000, 4};
    vt[2] = '{6'b000000, 6'b100001, 4};
    vt[3] = '{6'b000000, 6'b100011, 4};
    vt[4] = '{6'b001101, 6'b000000, 4};
    vt[5] = '{6'b000100, 6'b000000, 3};
    vt[6] = '{6'b000010, 6'b000000, 3};
    vt[7] = '{6'b000011, 6'b000000, 3};
    vt[8] = '{6'b000000, 6'b001000, 3};
    vt[9] = '{6'b001111, 6'b000000, 3};

    // Reset: enables are forced low even though FETCH would request a read.
    reset = 1'b0; mem_ready = 1'b1; op = 6'b100011;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_state", 32'(dbg_state), 32'(0));
    chk("rst_ctrl", 32'(act_ctrl()), 32'(exp_ctrl(0, 6'd0, 1'b1, 1'b0)));
    @(posedge clk); #1;
    reset = 1'b1;

    // lw directed walk: states 0..4, writeback from MDR in state 4.
    run_instr(6'b100011, 6'b000000, 1'b0);

    // Latency table.
    foreach (vt[i]) begin
      latency(vt[i].op, vt[i].funct, 1'b1, cyc);
      chk($sformatf("latency_op%02h_fn%02h", vt[i].op, vt[i].funct), 32'(cyc), 32'(vt[i].lat));
    end
    latency(6'b000100, 6'b000000, 1'b0, cyc);
    chk("latency_beq_nz", 32'(cyc), 32'(3));

    // FETCH stall: three wait cycles, then IR/PC load on the fourth only.
    op = 6'b000010; funct = '0;
    for (int k = 0; k < 4; k++) begin
      mem_ready = (k == 3);
      @(negedge clk);
      chk("stall_state", 32'(dbg_state), 32'(0));
      chk("stall_memread", 32'(MemRead), 32'(1));
      chk("stall_irw_pcw", 32'({IRWrite, PCWrite}), (k == 3) ? 32'(2'b11) : 32'(2'b00));
      @(posedge clk); #1;
    end
    mem_ready = 1'b1;
    @(posedge clk); #1;  // DECODE -> JUMP
    @(posedge clk); #1;  // JUMP -> FETCH

    // Randomized mix of legal instructions with random memory wait states.
    for (int n = 0; n < 150; n++) begin
      int pick = $urandom_range(0, 9);
      run_instr(vt[pick].op, vt[pick].funct, 1'b1);
    end

    // Illegal encoding locks the FSM until reset.
    run_instr(6'b000000, 6'b000000, 1'b0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("illegal_hold", 32'({dbg_state, illegal}), 32'({4'd15, 1'b1}));
      @(posedge clk); #1;
    end
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("illegal_clear", 32'({dbg_state, illegal}), 32'({4'd0, 1'b0}));

    // sw aborted by reset while waiting in MEMWR.
    op = 6'b101011; funct = '0; mem_ready = 1'b1;
    @(posedge clk); #1;  // FETCH -> DECODE
    @(posedge clk); #1;  // DECODE -> MEMADR
    @(posedge clk); #1;  // MEMADR -> MEMWR
    mem_ready = 1'b0;
    @(negedge clk);
    chk("sw_wait", 32'({dbg_state, MemWrite}), 32'({4'd5, 1'b1}));
    reset = 1'b0;
    #1;
    chk("sw_abort_comb", 32'({MemWrite, instr_done}), 32'(0));
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("sw_abort_state", 32'({dbg_state, instr_done, MemWrite}), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
